// File: rtl/seq_pkg.sv
// Shared types and default widths for the 1010 detector and its match logger.
package seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } logger_state_t;

  localparam int SEQ_CNT_W = 16;
  localparam int SEQ_TOT_W = 16;
  localparam int SEQ_DEPTH = 4;

endpackage

// File: rtl/seq_evt_fifo.sv
// Synchronous show-ahead FIFO with explicit occupancy count.
// A push is accepted when full only if a pop frees a slot in the same cycle.
module seq_evt_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       clr,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign level   = level_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is masked so the output reads zero whenever nothing is queued.
  assign dout    = empty ? '0 : mem[rd_q];

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (clr) begin
      wr_d    = '0;
      rd_d    = '0;
      level_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_q] <= din;
  end

endmodule

// File: rtl/seq_match_logger.sv
// Measures det-to-det gaps from the sequence detector, queues them for readout,
// and tracks a saturating match total plus a sticky drop flag.
module seq_match_logger
  import seq_pkg::*;
#(
  parameter int CNT_W = SEQ_CNT_W,
  parameter int TOT_W = SEQ_TOT_W,
  parameter int DEPTH = SEQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       clr,
  input  logic                       det,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [CNT_W-1:0]           ev_gap,
  output logic [TOT_W-1:0]           total,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     level
);

  logger_state_t    state_q, state_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [TOT_W-1:0] total_q, total_d;
  logic             ovf_q, ovf_d;
  logic             push, pop, empty, full;

  assign ev_valid = !empty;
  assign total    = total_q;
  assign overflow = ovf_q;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    total_d = total_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    pop     = ev_valid && ev_ready && !clr;
    if (clr) begin
      state_d = IDLE;
      gap_d   = '0;
      total_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (det && (total_q != '1)) total_d = total_q + 1'b1;
      case (state_q)
        IDLE: begin
          gap_d = '0;
          if (det) state_d = RUN;
        end
        RUN: begin
          if (det) begin
            push  = 1'b1;
            gap_d = '0;
          end else if (gap_q != '1) begin
            gap_d = gap_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      // A pop in the same cycle frees a slot, so only a lone push into a full FIFO drops.
      if (push && full && !pop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      gap_q   <= '0;
      total_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      total_q <= total_d;
      ovf_q   <= ovf_d;
    end
  end

  seq_evt_fifo #(
    .W     (CNT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (clr),
    .push  (push),
    .din   (gap_q),
    .pop   (pop),
    .dout  (ev_gap),
    .empty (empty),
    .full  (full),
    .level (level)
  );

endmodule

// File: tb/tb_seq_match_logger.sv
// Directed bench: default-width logger plus a narrow (CNT_W=4, TOT_W=3) copy on shared inputs.
module tb_seq_match_logger;

  logic clk = 1'b0;
  logic rstn, clr, det, ev_ready;

  logic        ev_valid, overflow;
  logic [15:0] ev_gap, total;
  logic [2:0]  level;

  logic        ev_valid4, overflow4;
  logic [3:0]  ev_gap4;
  logic [2:0]  total4;
  logic [2:0]  level4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_match_logger u_dut (
    .clk(clk), .rstn(rstn), .clr(clr), .det(det),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_gap(ev_gap),
    .total(total), .overflow(overflow), .level(level)
  );

  seq_match_logger #(.CNT_W(4), .TOT_W(3), .DEPTH(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .clr(clr), .det(det),
    .ev_valid(ev_valid4), .ev_ready(ev_ready), .ev_gap(ev_gap4),
    .total(total4), .overflow(overflow4), .level(level4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; clr = 1'b0; det = 1'b0; ev_ready = 1'b0;
    #22 rstn = 1'b1;
    tick(10);
    // reset / idle
    chk("rst_valid", ev_valid, 0);
    chk("rst_total", total, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf",   overflow, 0);
    chk("rst_gap",   ev_gap, 0);

    // det at relative cycles 0, 4, 5 with ready high
    ev_ready = 1'b1;
    det = 1'b1; tick();
    chk("t2_first_nopush", level, 0);
    chk("t2_first_total",  total, 1);
    det = 1'b0; tick(3);
    det = 1'b1; tick();
    chk("t2_ev1_valid", ev_valid, 1);
    chk("t2_ev1_gap",   ev_gap, 3);
    tick();
    chk("t2_ev2_gap",   ev_gap, 0);
    chk("t2_ev2_level", level, 1);
    chk("t2_total",     total, 3);
    det = 1'b0; tick();
    chk("t2_drained", ev_valid, 0);

    // fill past depth with ready low
    clr_pulse();
    ev_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      det = 1'b1; tick();
      det = 1'b0; tick();
    end
    chk("t3_level", level, 4);
    chk("t3_ovf",   overflow, 1);
    chk("t3_total", total, 6);
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain_valid", ev_valid, 1);
      chk("t3_drain_gap",   ev_gap, 1);
      tick();
    end
    chk("t3_empty_valid", ev_valid, 0);
    chk("t3_empty_level", level, 0);
    chk("t3_ovf_sticky",  overflow, 1);
    ev_ready = 1'b0;

    // full FIFO with simultaneous push and pop
    clr_pulse();
    chk("t4_ovf_cleared", overflow, 0);
    for (int i = 0; i < 5; i++) begin
      det = 1'b1; tick();
      det = 1'b0; tick();
    end
    tick();
    chk("t4_full_level", level, 4);
    det = 1'b1; ev_ready = 1'b1; tick();
    det = 1'b0;
    chk("t4_pp_level", level, 4);
    chk("t4_pp_ovf",   overflow, 0);
    chk("t4_e0", ev_gap, 1); tick();
    chk("t4_e1", ev_gap, 1); tick();
    chk("t4_e2", ev_gap, 1); tick();
    chk("t4_tail", ev_gap, 2); tick();
    chk("t4_empty", ev_valid, 0);
    ev_ready = 1'b0;

    // gap saturation on the narrow copy, then total saturation
    clr_pulse();
    det = 1'b1; tick();
    det = 1'b0; tick(20);
    det = 1'b1; tick();
    det = 1'b0;
    chk("t5_gap_sat",   ev_gap4, 15);
    chk("t5_gap_wide",  ev_gap, 20);
    chk("t5_valid4",    ev_valid4, 1);
    chk("t5_level4",    level4, 1);
    ev_ready = 1'b1; det = 1'b1; tick(8);
    det = 1'b0; ev_ready = 1'b0;
    chk("t5_total_sat",  total4, 7);
    chk("t5_total_wide", total, 10);
    chk("t5_ovf4",       overflow4, 0);
    tick();

    // clr beats det with two entries queued
    clr_pulse();
    det = 1'b1; tick();
    det = 1'b0; tick();
    det = 1'b1; tick();
    det = 1'b0; tick();
    det = 1'b1; tick();
    chk("t6_pre_level", level, 2);
    chk("t6_pre_total", total, 3);
    clr = 1'b1; det = 1'b1; tick();
    clr = 1'b0;
    chk("t6_clr_level", level, 0);
    chk("t6_clr_total", total, 0);
    chk("t6_clr_ovf",   overflow, 0);
    chk("t6_clr_valid", ev_valid, 0);
    tick();
    chk("t6_idle_nopush", level, 0);
    chk("t6_idle_total",  total, 1);
    det = 1'b0; tick();
    det = 1'b1; tick();
    det = 1'b0;
    chk("t6_run_level", level, 1);
    chk("t6_run_gap",   ev_gap, 1);

    // asynchronous reset mid-stream
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_valid", ev_valid, 0);
    chk("rst_mid_level", level, 0);
    chk("rst_mid_total", total, 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    det = 1'b1; tick();
    det = 1'b0;
    chk("rst_mid_idle_det", level, 0);
    chk("rst_mid_total1",   total, 1);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
